// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: default bus widths, FSM state encoding and prefetch depth.
package fetch_pkg;

  localparam int FETCH_WIDTH     = 16;
  localparam int FETCH_ADDR_BITS = 6;
  localparam int FB_DEPTH        = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding prefetched {instr, pc} entries; registered head, 1-cycle write-to-head.
// Caller never pushes when full without a same-cycle pop; flush clears everything and overrides push/pop.
module fetch_buffer #(
  parameter  int DW    = 22,
  parameter  int DEPTH = 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] push_dat,
  output logic [DW-1:0] head_dat,
  output logic [CW-1:0] count
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, addresses imem and queues {word, pc} for decode; word at T shows at T+1.
// Stalls the PC while the prefetch buffer is full and not popped; a redirect flushes and reloads the PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                   WIDTH     = FETCH_WIDTH,
  parameter int                   ADDR_BITS = FETCH_ADDR_BITS,
  parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  output logic [ADDR_BITS-1:0] imem_adr,
  input  logic [WIDTH-1:0]     imem_data,
  input  logic                 redirect_valid,
  input  logic [ADDR_BITS-1:0] redirect_pc,
  output logic                 instr_valid,
  output logic [WIDTH-1:0]     instr,
  output logic [ADDR_BITS-1:0] instr_pc,
  input  logic                 instr_ready
);

  localparam int EW = WIDTH + ADDR_BITS;
  localparam int CW = $clog2(FB_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(FB_DEPTH);

  fetch_state_t         state_q;
  fetch_state_t         state_d;
  logic [ADDR_BITS-1:0] pc_q;
  logic [CW-1:0]        count;
  logic [EW-1:0]        head_dat;
  logic                 push;
  logic                 pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (redirect_valid) pc_q <= redirect_pc;
      else if (push)      pc_q <= pc_q + ADDR_BITS'(1);
    end
  end

  // A full buffer may still accept a word when decode drains the head in the same cycle.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN: begin
        if (!en) state_d = ST_IDLE;
        push = en & ~redirect_valid & ((count < FULL) | pop);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pop         = instr_valid & instr_ready;
  assign instr_valid = (count != '0);
  assign instr       = head_dat[EW-1 -: WIDTH];
  assign instr_pc    = head_dat[ADDR_BITS-1:0];
  assign imem_adr    = pc_q;

  fetch_buffer #(
    .DW    (EW),
    .DEPTH (FB_DEPTH)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (redirect_valid),
    .push_dat ({imem_data, pc_q}),
    .head_dat (head_dat),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: combinational imem model mem[i]=16'hA000+i, scoreboard of expected PCs.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [5:0]  imem_adr;
  logic [15:0] imem_data;
  logic        redirect_valid;
  logic [5:0]  redirect_pc;
  logic        instr_valid;
  logic [15:0] instr;
  logic [5:0]  instr_pc;
  logic        instr_ready;

  int          checks = 0;
  int          errors = 0;
  logic [5:0]  exp_q[$];
  logic [5:0]  exp_pc;

  always #5 clk = ~clk;

  assign imem_data = 16'hA000 + {10'd0, imem_adr};

  fetch_unit #(
    .WIDTH     (16),
    .ADDR_BITS (6),
    .RESET_PC  (6'd0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .imem_adr       (imem_adr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  // Each task is entered and left 1 time unit after a falling edge.
  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    checks++; if (instr !== 16'h0) begin errors++; $display("FAIL reset_instr: got %h want 0000", instr); end
    checks++; if (instr_pc !== 6'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", instr_pc); end
    checks++; if (imem_adr !== 6'd0) begin errors++; $display("FAIL reset_adr: got %0d want 0", imem_adr); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b0 || imem_adr !== 6'd0) begin
      errors++; $display("FAIL idle_hold: got valid=%b adr=%0d want 0/0", instr_valid, imem_adr);
    end
  endtask

  task automatic test_stream();
    en = 1'b1; instr_ready = 1'b1;
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early: got valid=%b want 0", instr_valid); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stream_first: got valid=%b want 1", instr_valid); end
    for (int i = 0; i < 8; i++) exp_q.push_back(6'(i));
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      checks++;
      if (instr_valid !== 1'b1) begin
        errors++; $display("FAIL stream_gap: got valid=%b want 1", instr_valid);
      end else begin
        exp_pc = exp_q.pop_front();
        if (instr_pc !== exp_pc || instr !== 16'hA000 + 16'(exp_pc)) begin
          errors++; $display("FAIL stream_word: got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, exp_pc, 16'hA000 + 16'(exp_pc));
        end
      end
      @(negedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stream_timeout: got %0d words missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_stall();
    rst_n = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1; en = 1'b1; instr_ready = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (instr_valid) begin
        checks++;
        if (instr !== 16'hA000 || instr_pc !== 6'd0) begin
          errors++; $display("FAIL stall_stable: got pc=%0d instr=%h want pc=0 instr=a000", instr_pc, instr);
        end
      end
    end
    checks++; if (imem_adr !== 6'd2) begin errors++; $display("FAIL stall_adr: got %0d want 2", imem_adr); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", instr_valid); end
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(6'(i));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      checks++;
      if (instr_valid !== 1'b1) begin
        errors++; $display("FAIL stall_gap: got valid=%b want 1", instr_valid);
      end else begin
        exp_pc = exp_q.pop_front();
        if (instr_pc !== exp_pc || instr !== 16'hA000 + 16'(exp_pc)) begin
          errors++; $display("FAIL stall_word: got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, exp_pc, 16'hA000 + 16'(exp_pc));
        end
      end
      @(negedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_timeout: got %0d words missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect_full();
    instr_ready = 1'b0;
    repeat (3) begin @(negedge clk); #1; end
    redirect_pc = 6'd40; redirect_valid = 1'b1;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    checks++; if (imem_adr !== 6'd40) begin errors++; $display("FAIL redir_adr: got %0d want 40", imem_adr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush: got valid=%b want 0", instr_valid); end
    @(negedge clk); #1;
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 6'd40 || instr !== 16'hA028) begin
      errors++; $display("FAIL redir_target: got valid=%b pc=%0d instr=%h want 1/40/a028", instr_valid, instr_pc, instr);
    end
    instr_ready = 1'b1;
    for (int i = 40; i < 44; i++) exp_q.push_back(6'(i));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        exp_pc = exp_q.pop_front();
        checks++;
        if (instr_pc !== exp_pc || instr !== 16'hA000 + 16'(exp_pc)) begin
          errors++; $display("FAIL redir_word: got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, exp_pc, 16'hA000 + 16'(exp_pc));
        end
      end
      @(negedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL redir_timeout: got %0d words missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_wrap();
    redirect_pc = 6'd62; redirect_valid = 1'b1;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    exp_q.push_back(6'd62); exp_q.push_back(6'd63); exp_q.push_back(6'd0); exp_q.push_back(6'd1);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        exp_pc = exp_q.pop_front();
        checks++;
        if (instr_pc !== exp_pc || instr !== 16'hA000 + 16'(exp_pc)) begin
          errors++; $display("FAIL wrap_word: got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, exp_pc, 16'hA000 + 16'(exp_pc));
        end
      end
      @(negedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_timeout: got %0d words missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect_pop();
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL rpop_pre: got valid=%b want 1", instr_valid); end
    redirect_pc = 6'd20; redirect_valid = 1'b1; instr_ready = 1'b1;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush: got valid=%b want 0", instr_valid); end
    for (int i = 20; i < 24; i++) exp_q.push_back(6'(i));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        exp_pc = exp_q.pop_front();
        checks++;
        if (instr_pc !== exp_pc || instr !== 16'hA000 + 16'(exp_pc)) begin
          errors++; $display("FAIL rpop_word: got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, exp_pc, 16'hA000 + 16'(exp_pc));
        end
      end
      @(negedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rpop_timeout: got %0d words missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_redirect_idle();
    en = 1'b0; instr_ready = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_drain: got valid=%b want 0", instr_valid); end
    redirect_pc = 6'd10; redirect_valid = 1'b1;
    @(negedge clk); #1;
    redirect_valid = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    checks++; if (imem_adr !== 6'd10 || instr_valid !== 1'b0) begin
      errors++; $display("FAIL idle_redir: got adr=%0d valid=%b want 10/0", imem_adr, instr_valid);
    end
    en = 1'b1;
    for (int i = 10; i < 13; i++) exp_q.push_back(6'(i));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        exp_pc = exp_q.pop_front();
        checks++;
        if (instr_pc !== exp_pc || instr !== 16'hA000 + 16'(exp_pc)) begin
          errors++; $display("FAIL idle_word: got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, exp_pc, 16'hA000 + 16'(exp_pc));
        end
      end
      @(negedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL idle_timeout: got %0d words missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b want 0", instr_valid); end
    checks++; if (imem_adr !== 6'd0) begin errors++; $display("FAIL areset_adr: got %0d want 0", imem_adr); end
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(6'(i));
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      if (instr_valid && instr_ready) begin
        exp_pc = exp_q.pop_front();
        checks++;
        if (instr_pc !== exp_pc || instr !== 16'hA000 + 16'(exp_pc)) begin
          errors++; $display("FAIL areset_word: got pc=%0d instr=%h want pc=%0d instr=%h", instr_pc, instr, exp_pc, 16'hA000 + 16'(exp_pc));
        end
      end
      @(negedge clk); #1;
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL areset_timeout: got %0d words missing want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_full();
    test_wrap();
    test_redirect_pop();
    test_redirect_idle();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
